// File: rtl/gppcu_dispatcher_pkg.sv
// Shared widths, FSM state encoding and the read-admission rule for the
// GPPCU instruction dispatcher.
package gppcu_dispatcher_pkg;

   localparam int DBW_DEFAULT  = 32;
   localparam int IABW_DEFAULT = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // A new read may start only if queued words plus the read still in flight,
   // less the word leaving this cycle, leaves room in the two-entry buffer.
   function automatic logic fifo_has_room(input logic [1:0] entries,
                                          input logic       in_flight,
                                          input logic       pop);
      logic [2:0] occ;
      occ = {1'b0, entries} + {2'b00, in_flight} - {2'b00, pop};
      return (occ < 3'd2);
   endfunction

endpackage

// File: rtl/gppcu_dispatcher_if.sv
// Control, instruction-memory and core-side signals of the dispatcher,
// bundled with modports for the dispatcher (slave) and its host (master).
interface gppcu_dispatcher_if
   import gppcu_dispatcher_pkg::*;
#(
   parameter int DBW  = DBW_DEFAULT,
   parameter int IABW = IABW_DEFAULT
);
   logic            iSTART;
   logic            iABORT;
   logic [IABW-1:0] iBASE_ADDR;
   logic [IABW:0]   iCOUNT;
   logic            oBUSY;
   logic            oDONE;
   logic [IABW-1:0] oIMEM_ADDR;
   logic            oIMEM_RD;
   logic [DBW-1:0]  iIMEM_RDATA;
   logic [DBW-1:0]  oINSTR;
   logic            oINSTR_VALID;
   logic            iINSTR_READY;
   logic [IABW:0]   oISSUED;

   modport slave (
      input  iSTART, iABORT, iBASE_ADDR, iCOUNT, iIMEM_RDATA, iINSTR_READY,
      output oBUSY, oDONE, oIMEM_ADDR, oIMEM_RD, oINSTR, oINSTR_VALID, oISSUED
   );

   modport master (
      output iSTART, iABORT, iBASE_ADDR, iCOUNT, iIMEM_RDATA, iINSTR_READY,
      input  oBUSY, oDONE, oIMEM_ADDR, oIMEM_RD, oINSTR, oINSTR_VALID, oISSUED
   );
endinterface

// File: rtl/gppcu_dispatcher_skid.sv
// Two-entry instruction buffer between instruction memory and the core.
// Flush empties it and wins over a push or pop in the same cycle.
module gppcu_instr_skid #(
   parameter int DW = 32
) (
   input  logic          iACLK,
   input  logic          iRST,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] head_o,
   output logic [1:0]    count_o,
   output logic          valid_o
);
   logic [DW-1:0] mem_q [2];
   logic          wptr_q;
   logic          rptr_q;
   logic [1:0]    count_q;
   logic          do_push_s;
   logic          do_pop_s;

   assign do_pop_s  = pop_i && (count_q != 2'd0);
   assign do_push_s = push_i && ((count_q != 2'd2) || do_pop_s);

   // storage, pointers and occupancy
   always_ff @(posedge iACLK or posedge iRST) begin
      if (iRST) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush_i) begin
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push_s) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= ~wptr_q;
         end
         if (do_pop_s) begin
            rptr_q <= ~rptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign valid_o = (count_q != 2'd0);

endmodule

// File: rtl/gppcu_dispatcher.sv
// Kernel dispatcher: streams a contiguous block of instructions from
// instruction memory into the core through a two-entry buffer.
module gppcu_dispatcher
   import gppcu_dispatcher_pkg::*;
#(
   parameter int DBW  = DBW_DEFAULT,
   parameter int IABW = IABW_DEFAULT
) (
   input  logic              iACLK,
   input  logic              iRST,
   gppcu_dispatcher_if.slave bus
);
   localparam logic [IABW:0]   CNT_ONE  = {{IABW{1'b0}}, 1'b1};
   localparam logic [IABW-1:0] ADDR_ONE = {{(IABW-1){1'b0}}, 1'b1};

   state_e          state_q;
   logic [IABW-1:0] addr_q;
   logic [IABW:0]   remain_q;
   logic [IABW:0]   count_q;
   logic [IABW:0]   issued_q;
   logic            pend_q;

   logic [1:0]      fifo_count_s;
   logic            fifo_valid_s;
   logic [DBW-1:0]  fifo_head_s;
   logic            handshake_s;
   logic            issue_s;
   logic            last_hs_s;

   assign handshake_s = fifo_valid_s && bus.iINSTR_READY;
   assign last_hs_s   = handshake_s && ((issued_q + CNT_ONE) == count_q);

   // read issue decision; abort suppresses any read in its cycle
   always_comb begin
      issue_s = 1'b0;
      if ((state_q == ST_FETCH) && !bus.iABORT && (remain_q != '0)) begin
         issue_s = fifo_has_room(fifo_count_s, pend_q, handshake_s);
      end else begin
         issue_s = 1'b0;
      end
   end

   // kernel FSM with address, count and issued-instruction bookkeeping
   always_ff @(posedge iACLK or posedge iRST) begin
      if (iRST) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         count_q  <= '0;
         issued_q <= '0;
         pend_q   <= 1'b0;
      end else begin
         pend_q <= issue_s;
         if (handshake_s && (issued_q != count_q)) begin
            issued_q <= issued_q + CNT_ONE;
         end
         if (issue_s) begin
            addr_q   <= addr_q + ADDR_ONE;
            remain_q <= remain_q - CNT_ONE;
         end
         case (state_q)
            ST_IDLE: begin
               if (bus.iABORT) begin
                  state_q <= ST_IDLE;
               end else if (bus.iSTART) begin
                  addr_q   <= bus.iBASE_ADDR;
                  remain_q <= bus.iCOUNT;
                  count_q  <= bus.iCOUNT;
                  issued_q <= '0;
                  state_q  <= (bus.iCOUNT == '0) ? ST_DONE : ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (bus.iABORT) begin
                  state_q <= ST_IDLE;
               end else if (issue_s && (remain_q == CNT_ONE)) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (bus.iABORT) begin
                  state_q <= ST_IDLE;
               end else if (last_hs_s) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // abort flushes queued words and discards the read arriving this cycle
   gppcu_instr_skid #(.DW(DBW)) u_skid (
      .iACLK   (iACLK),
      .iRST    (iRST),
      .push_i  (pend_q),
      .pop_i   (handshake_s),
      .flush_i (bus.iABORT),
      .data_i  (bus.iIMEM_RDATA),
      .head_o  (fifo_head_s),
      .count_o (fifo_count_s),
      .valid_o (fifo_valid_s)
   );

   assign bus.oBUSY        = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign bus.oDONE        = (state_q == ST_DONE) && !bus.iABORT;
   assign bus.oIMEM_ADDR   = addr_q;
   assign bus.oIMEM_RD     = issue_s;
   assign bus.oINSTR       = fifo_head_s;
   assign bus.oINSTR_VALID = fifo_valid_s;
   assign bus.oISSUED      = issued_q;

endmodule
